iic_bit_engine: RTL and testbench
=================================

Name: iic_bit_engine

Overview:
- Bit-level I2C master engine directly downstream of the I2C transaction controller.
- Consumes the one-hot phase requests trans_start/chip/reg/data/stop and the muxed byte.
- Drives open-drain SCL/SDA, samples ACK and read data, and returns a one-cycle finish_* pulse per phase.
- Timing is built from a quarter-SCL-period tick.

Parameters:
QDIV, 25, system clocks per SCL quarter period (SCL period = 4*QDIV clocks); legal range >= 2
QW, 8, width of quarter counter; must hold QDIV-1

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
trans_start  input  1  request START condition
trans_chip  input  1  request chip-address byte
trans_reg  input  1  request register byte
trans_data  input  1  request data byte
trans_stop  input  1  request STOP condition
tx_byte  input  8  byte to send, MSB first
sda_i  input  1  SDA line level
scl_i  input  1  SCL line level (used only with IIC_CLK_STRETCH_EN)
scl_oe  output  1  1 = pull SCL low, 0 = release
sda_oe  output  1  1 = pull SDA low, 0 = release
finish_start  output  1  one-cycle pulse, START done
finish_chip  output  1  one-cycle pulse, chip byte + ACK done
finish_reg  output  1  one-cycle pulse, reg byte + ACK done
finish_data  output  1  one-cycle pulse, data byte + ACK done
finish_stop  output  1  one-cycle pulse, STOP done
ack_err  output  1  sticky NACK flag
rx_byte  output  8  last 8 SDA samples of the most recent byte phase

Behaviour:
- Reset (async, rstn=0): state IDLE; scl_oe=0, sda_oe=0; all finish_*=0; ack_err=0; rx_byte=0; counters 0. Reset mid-phase aborts immediately and releases both lines.
- States: IDLE, START, BYTE, STOP, DONE.
- IDLE: samples trans_* each clk. Priority if several are high: start > chip > reg > data > stop.
  - On acceptance, latch tx_byte (byte phases) and the phase id; enter the phase next cycle.
  - trans_start acceptance clears ack_err.
- Quarter tick: qcnt counts 0..QDIV-1; a tick is issued at QDIV-1; quarter index q counts 0..3.
- Once accepted, a phase runs to completion regardless of trans_* level.
- START (one bit time): q0,q1 SCL rel, SDA rel; q2 SCL rel, SDA low; q3 SCL low, SDA low.
- BYTE: 9 bit times (bits 7..0 of latched byte, then ACK slot). Per bit:
  - q0 SCL low, SDA = bit (0 -> pull, 1 -> release); q1,q2 SCL rel; q3 SCL low.
  - ACK slot releases SDA for all 4 quarters.
  - sda_i sampled on the q1->q2 tick. Data bits shift into rx_byte, MSB first.
  - ACK sample of 1 sets ack_err.
- STOP (one bit time): q0 SCL low, SDA low; q1 SCL rel, SDA low; q2,q3 SCL rel, SDA rel.
- DONE (one cycle): the matching finish_* = 1, line outputs hold, then return to IDLE. trans_* is not accepted in DONE.
- Line outputs hold their last value while IDLE between phases. After STOP both lines are released.
- Latency: trans accepted on edge N -> finish pulse in cycle N+1+4*QDIV*k (k=1 START/STOP, k=9 byte).
- ack_err persists through later phases until the next START accept. A NACK does not change sequencing; the controller decides.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: IIC_CLK_STRETCH_EN.
- Defined: in any quarter where SCL is released, qcnt holds at 0 until scl_i reads 1 (slave clock stretching). Each stall cycle extends the latency by one.
- Undefined: scl_i is ignored and timing is fixed as above.

Test Plan:
- QDIV=4, trans_start high at cycle 0 -> SDA falls while SCL released (cycle 9); finish_start single pulse at cycle 17; scl_oe=1 and sda_oe=1 after.
- trans_chip with tx_byte=0xA4, slave ACKs (sda_i=0 in ACK slot) -> SDA pattern 1,0,1,0,0,1,0,0 across 8 SCL highs; finish_chip at cycle 145 after accept; ack_err=0.
- trans_data with tx_byte=0x3C, sda_i held 1 in ACK slot -> ack_err=1 after finish_data, still 1 after STOP; cleared on next trans_start accept.
- trans_chip and trans_reg asserted together -> chip accepted; exactly one finish_chip pulse and no finish_reg.
- rstn pulled low mid-byte (bit 4, q2) -> scl_oe=0, sda_oe=0, no finish_* same cycle; after release, trans_start accepted normally.
- IIC_CLK_STRETCH_EN defined, scl_i forced 0 for 10 cycles in bit 0 q1 of a byte -> finish_* delayed by exactly 10 cycles vs. baseline.

Source files
------------

// File: rtl/iic_bit_engine.sv
// Bit-level I2C master: open-drain SCL/SDA sequencing driven by a quarter-SCL-period tick.
// Define IIC_CLK_STRETCH_EN to let a slave stretch SCL (sampled via scl_i).
module iic_bit_engine #(
  parameter int QDIV = 25,
  parameter int QW   = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       trans_start,
  input  logic       trans_chip,
  input  logic       trans_reg,
  input  logic       trans_data,
  input  logic       trans_stop,
  input  logic [7:0] tx_byte,
  input  logic       sda_i,
  input  logic       scl_i,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       finish_start,
  output logic       finish_chip,
  output logic       finish_reg,
  output logic       finish_data,
  output logic       finish_stop,
  output logic       ack_err,
  output logic [7:0] rx_byte
);

  localparam logic [2:0]    S_IDLE  = 3'd0;
  localparam logic [2:0]    S_START = 3'd1;
  localparam logic [2:0]    S_BYTE  = 3'd2;
  localparam logic [2:0]    S_STOP  = 3'd3;
  localparam logic [2:0]    S_DONE  = 3'd4;
  localparam logic [QW-1:0] QLAST   = QW'(QDIV - 1);

  logic [2:0]    r_state, w_nstate;
  logic [1:0]    r_q, w_nq;
  logic [QW-1:0] r_qcnt;
  logic [3:0]    r_bit;
  logic [7:0]    r_tx, r_rx;
  logic [4:0]    r_phase, w_req, r_fin;
  logic          r_scl_oe, r_sda_oe, r_ack_err;
  logic          w_nscl_oe, w_nsda_oe;
  logic          w_busy, w_tick, w_stall, w_scl_rel, w_last_bit, w_accept;

  // Fixed-priority one-hot request: start > chip > reg > data > stop
  always_comb begin
    w_req = 5'b00000;
    if (trans_start)     w_req = 5'b00001;
    else if (trans_chip) w_req = 5'b00010;
    else if (trans_reg)  w_req = 5'b00100;
    else if (trans_data) w_req = 5'b01000;
    else if (trans_stop) w_req = 5'b10000;
    else                 w_req = 5'b00000;
  end

  assign w_accept   = (r_state == S_IDLE) && (w_req != 5'b00000);
  assign w_busy     = (r_state == S_START) || (r_state == S_BYTE) || (r_state == S_STOP);
  assign w_last_bit = (r_state != S_BYTE) || (r_bit == 4'd8);

  // Quarters in which the master leaves SCL released
  always_comb begin
    w_scl_rel = 1'b0;
    case (r_state)
      S_START: w_scl_rel = (r_q != 2'd3);
      S_BYTE:  w_scl_rel = (r_q == 2'd1) || (r_q == 2'd2);
      S_STOP:  w_scl_rel = (r_q != 2'd0);
      default: w_scl_rel = 1'b0;
    endcase
  end

`ifdef IIC_CLK_STRETCH_EN
  assign w_stall = w_scl_rel && (r_qcnt == {QW{1'b0}}) && !scl_i;
`else
  assign w_stall = w_scl_rel & scl_i & 1'b0;
`endif

  assign w_tick = w_busy && !w_stall && (r_qcnt == QLAST);

  // Next state and quarter index
  always_comb begin
    w_nstate = r_state;
    w_nq     = r_q;
    case (r_state)
      S_IDLE: begin
        w_nq = 2'd0;
        if (w_req[0])               w_nstate = S_START;
        else if (w_req[4])          w_nstate = S_STOP;
        else if (w_req != 5'b00000) w_nstate = S_BYTE;
        else                        w_nstate = S_IDLE;
      end
      S_START, S_BYTE, S_STOP: begin
        if (w_tick) begin
          w_nq = r_q + 2'd1;
          if ((r_q == 2'd3) && w_last_bit) w_nstate = S_DONE;
          else                             w_nstate = r_state;
        end else begin
          w_nstate = r_state;
        end
      end
      S_DONE:  w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  // SCL follows the upcoming quarter so a stretch is visible from that quarter's first cycle
  always_comb begin
    w_nscl_oe = r_scl_oe;
    case (w_nstate)
      S_START: w_nscl_oe = (w_nq == 2'd3);
      S_BYTE:  w_nscl_oe = (w_nq == 2'd0) || (w_nq == 2'd3);
      S_STOP:  w_nscl_oe = (w_nq == 2'd0);
      default: w_nscl_oe = r_scl_oe;
    endcase
  end

  // SDA follows the current quarter, one cycle behind, so it never moves on a SCL edge
  always_comb begin
    w_nsda_oe = r_sda_oe;
    case (r_state)
      S_START: w_nsda_oe = r_q[1];
      S_BYTE:  w_nsda_oe = (r_bit == 4'd8) ? 1'b0 : !r_tx[7];
      S_STOP:  w_nsda_oe = !r_q[1];
      default: w_nsda_oe = r_sda_oe;
    endcase
  end

  // Sequencing registers and line drivers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_q      <= 2'd0;
      r_qcnt   <= {QW{1'b0}};
      r_scl_oe <= 1'b0;
      r_sda_oe <= 1'b0;
      r_fin    <= 5'b00000;
    end else begin
      r_state  <= w_nstate;
      r_q      <= w_nq;
      r_scl_oe <= w_nscl_oe;
      r_sda_oe <= w_nsda_oe;
      r_fin    <= (r_state == S_DONE) ? r_phase : 5'b00000;
      if (!w_busy || w_tick) r_qcnt <= {QW{1'b0}};
      else if (!w_stall)     r_qcnt <= r_qcnt + QW'(1);
      else                   r_qcnt <= r_qcnt;
    end
  end

  // Phase latch, byte shifter, read sampling and sticky NACK flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_phase   <= 5'b00000;
      r_tx      <= 8'h00;
      r_bit     <= 4'd0;
      r_rx      <= 8'h00;
      r_ack_err <= 1'b0;
    end else if (w_accept) begin
      r_phase <= w_req;
      r_tx    <= tx_byte;
      r_bit   <= 4'd0;
      if (w_req[0]) r_ack_err <= 1'b0;
    end else if ((r_state == S_BYTE) && w_tick) begin
      if (r_q == 2'd1) begin
        if (r_bit != 4'd8) r_rx <= {r_rx[6:0], sda_i};
        else if (sda_i)    r_ack_err <= 1'b1;
      end
      if (r_q == 2'd3) begin
        r_bit <= r_bit + 4'd1;
        r_tx  <= {r_tx[6:0], 1'b0};
      end
    end
  end

  assign scl_oe       = r_scl_oe;
  assign sda_oe       = r_sda_oe;
  assign finish_start = r_fin[0];
  assign finish_chip  = r_fin[1];
  assign finish_reg   = r_fin[2];
  assign finish_data  = r_fin[3];
  assign finish_stop  = r_fin[4];
  assign ack_err      = r_ack_err;
  assign rx_byte      = r_rx;

endmodule

// File: tb/tb_iic_bit_engine.sv
// Randomized self-checking bench for iic_bit_engine against a phase-level bus model.
module tb_iic_bit_engine;
  localparam int Q   = 4;
  localparam int BIT = 4 * Q;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       trans_start = 1'b0, trans_chip = 1'b0, trans_reg = 1'b0;
  logic       trans_data = 1'b0, trans_stop = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       sda_i, scl_i;
  logic       scl_oe, sda_oe, ack_err;
  logic       finish_start, finish_chip, finish_reg, finish_data, finish_stop;
  logic [7:0] rx_byte;
  logic [4:0] fin;

  logic       slave_rel = 1'b1;
  logic       stretch = 1'b0;
  logic       prev_scl = 1'b0;
  bit         rise_bits[$];
  int         checks = 0;
  int         failures = 0;
  logic       exp_ack = 1'b0;
  logic [7:0] exp_rx = 8'h00;

  iic_bit_engine #(.QDIV(Q), .QW(8)) dut (
    .clk(clk), .rstn(rstn),
    .trans_start(trans_start), .trans_chip(trans_chip), .trans_reg(trans_reg),
    .trans_data(trans_data), .trans_stop(trans_stop), .tx_byte(tx_byte),
    .sda_i(sda_i), .scl_i(scl_i), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .finish_start(finish_start), .finish_chip(finish_chip), .finish_reg(finish_reg),
    .finish_data(finish_data), .finish_stop(finish_stop),
    .ack_err(ack_err), .rx_byte(rx_byte)
  );

  assign sda_i = !sda_oe && slave_rel;
  assign scl_i = !scl_oe && !stretch;
  assign fin   = {finish_stop, finish_data, finish_reg, finish_chip, finish_start};

  always #5 clk = ~clk;

  // Record the master's SDA level at every SCL rising edge
  always @(negedge clk) begin
    if (prev_scl && !scl_oe) rise_bits.push_back(!sda_oe);
    prev_scl <= scl_oe;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic run_phase(input logic [4:0] mask, input logic [7:0] byt, input logic [7:0] slv,
                           input logic slv_ack, input int stretch_at);
    int kind, k, exp_t, got_t;
    logic [4:0] exp_fin;
    logic [7:0] seen;
    kind = 0;
    while (!mask[kind]) kind++;
    exp_fin = 5'd1 << kind;
    k = (kind == 0 || kind == 4) ? 1 : 9;
    exp_t = 1 + BIT * k + ((stretch_at > 0) ? 10 : 0);
    {trans_stop, trans_data, trans_reg, trans_chip, trans_start} = mask;
    tx_byte = byt;
    @(posedge clk); #1;
    {trans_stop, trans_data, trans_reg, trans_chip, trans_start} = 5'b00000;
    tx_byte = 8'($urandom);
    rise_bits.delete();
    got_t = 0;
    for (int t = 1; t <= exp_t + 8 && got_t == 0; t++) begin
      int tt, b;
      tt = t;
      if (stretch_at > 0 && t > stretch_at) tt = (t > stretch_at + 10) ? t - 10 : stretch_at;
      b = (tt - 1) / BIT;
      if (k == 9) slave_rel = (b < 8) ? slv[7 - b] : ((b == 8) ? slv_ack : 1'b1);
      else        slave_rel = 1'b1;
      stretch = (stretch_at > 0) && (t > stretch_at) && (t <= stretch_at + 10);
      @(posedge clk); #1;
      if (kind == 0 && t == 2 * Q + 1) check_eq("start_sda_fall", 32'({scl_oe, sda_oe}), 32'h1);
      if (fin != 5'b00000) begin
        got_t = t;
        check_eq("finish_which", 32'(fin), 32'(exp_fin));
      end
    end
    stretch = 1'b0;
    slave_rel = 1'b1;
    check_eq("finish_time", 32'(got_t), 32'(exp_t));
    @(posedge clk); #1;
    check_eq("finish_width", 32'(fin), 32'h0);
    if (kind == 0) exp_ack = 1'b0;
    if (k == 9) begin
      exp_ack = exp_ack | slv_ack;
      exp_rx  = byt & slv;
      check_eq("scl_rises", 32'(rise_bits.size()), 32'd9);
      seen = 8'h00;
      for (int i = 0; i < 8 && i < rise_bits.size(); i++) seen[7 - i] = rise_bits[i];
      check_eq("sda_bits", 32'(seen), 32'(byt));
      if (rise_bits.size() > 8) check_eq("ack_slot_rel", 32'(rise_bits[8]), 32'h1);
    end
    if (kind == 0) check_eq("after_start", 32'({scl_oe, sda_oe}), 32'h3);
    if (kind == 4) check_eq("after_stop", 32'({scl_oe, sda_oe}), 32'h0);
    check_eq("ack_err", 32'(ack_err), 32'(exp_ack));
    check_eq("rx_byte", 32'(rx_byte), 32'(exp_rx));
  endtask

  initial begin
    logic [4:0] m;
    idle(3);
    check_eq("reset_lines", 32'({scl_oe, sda_oe}), 32'h0);
    check_eq("reset_fin", 32'(fin), 32'h0);
    check_eq("reset_regs", 32'({ack_err, rx_byte}), 32'h0);
    rstn = 1'b1;
    idle(2);

    run_phase(5'b00001, 8'h00, 8'hFF, 1'b0, 0);
    run_phase(5'b00010, 8'hA4, 8'hFF, 1'b0, 0);
    run_phase(5'b00100, 8'($urandom), 8'($urandom), 1'b0, 0);
    run_phase(5'b01000, 8'h3C, 8'hFF, 1'b1, 0);
    run_phase(5'b10000, 8'h00, 8'hFF, 1'b0, 0);
    run_phase(5'b00001, 8'h00, 8'hFF, 1'b0, 0);
    run_phase(5'b00110, 8'h5A, 8'hFF, 1'b0, 0);
    run_phase(5'b01000, 8'h81, 8'hFF, 1'b1, 0);

    // Abort in the middle of a byte (bit 4, quarter 2)
    trans_chip = 1'b1;
    tx_byte = 8'h00;
    @(posedge clk); #1;
    trans_chip = 1'b0;
    idle(3 * BIT + 2 * Q + 1);
    check_eq("pre_abort_sda", 32'(sda_oe), 32'h1);
    #2 rstn = 1'b0;
    #1;
    check_eq("abort_lines", 32'({scl_oe, sda_oe}), 32'h0);
    check_eq("abort_fin", 32'(fin), 32'h0);
    check_eq("abort_regs", 32'({ack_err, rx_byte}), 32'h0);
    exp_ack = 1'b0;
    exp_rx = 8'h00;
    @(posedge clk); #1;
    rstn = 1'b1;
    idle(1);
    run_phase(5'b00001, 8'h00, 8'hFF, 1'b0, 0);

    for (int n = 0; n < 20; n++) begin
      m = 5'd1 << $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0) m = 5'($urandom_range(1, 31));
      idle($urandom_range(0, 3));
      run_phase(m, 8'($urandom), ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom),
                1'($urandom_range(0, 1)), 0);
    end

`ifdef IIC_CLK_STRETCH_EN
    run_phase(5'b00001, 8'h00, 8'hFF, 1'b0, 0);
    run_phase(5'b01000, 8'hC3, 8'hFF, 1'b0, 7 * BIT + Q);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
